wm8731_adc_ctrl: RTL and testbench
==================================

# wm8731_adc_ctrl

Master-mode controller for the WM8731 ADC serial interface. Generates `m_clk`, `b_clk` and `adc_lr_clk` from the system clock and deserialises `adcdat` into 16-bit left/right sample pairs. Hands each completed sample pair downstream over a valid/ready handshake. Sits between the codec pins (or the `adc_fm` bench model) and the audio datapath.

## Interface
- `MCLK_DIV`, default 2: clk cycles per `m_clk` period; even, ≥2.
- `BCLK_DIV`, default 8: clk cycles per `b_clk` period; even, ≥4.
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `enable` input, 1 bit: level; high runs the interface, low stops it at the next frame boundary.
- `adcdat` input, 1 bit: serial ADC data from the codec; MSB first; changes on `b_clk` falling edges.
- `m_clk` output, 1 bit: codec master clock.
- `b_clk` output, 1 bit: bit clock.
- `adc_lr_clk` output, 1 bit: frame clock; high for slots 0–15, low for slots 16–31.
- `left` output, 16 bits: left sample, frame bits 31..16.
- `right` output, 16 bits: right sample, frame bits 15..0.
- `sample_valid` output, 1 bit: `left`/`right` hold an unconsumed pair.
- `sample_ready` input, 1 bit: downstream accepts the pair.
- `overrun` output, 1 bit: sticky; a completed frame was dropped.
- `busy` output, 1 bit: high in any state other than IDLE.

## Operation
- States: IDLE, RUN, STOP.
- IDLE: `m_clk`, `b_clk` and `adc_lr_clk` are held low. `div_cnt` = BCLK_DIV-1. Slot counter `bit_cnt` = 31. The primed flag is clear.
- IDLE -> RUN when `enable` = 1. Entering RUN clears `overrun`.
- RUN -> STOP when `enable` = 0.
- Frame structure: each frame is 32 slots of one `b_clk` period each.
- Bit-clock counter: `div_cnt` counts 0..BCLK_DIV-1 and wraps.
  - `b_clk` is high for `div_cnt` < BCLK_DIV/2 and low otherwise.
  - Rise cycle: the clk cycle with `div_cnt` = BCLK_DIV-1. On that edge `div_cnt` wraps to 0, `b_clk` goes high, and `bit_cnt` increments modulo 32.
- `adc_lr_clk` = (`bit_cnt` < 16). It rises together with `b_clk` at slot 0.
- `m_clk` toggles every MCLK_DIV/2 clk cycles in RUN and STOP. Its counter is independent of `div_cnt`.
- Capture: on every rise cycle, `adcdat` shifts into a 32-bit register `shreg` (LSB in). No synchroniser: `adcdat` has been stable for half a `b_clk` period.
- Bit mapping:
  - The capture that starts slot k+1 takes the frame bit driven during slot k.
  - Bit 31 is captured at the start of slot 1.
  - Bit 0 is captured at the start of slot 0 of the next frame.
- The primed flag sets on the capture that starts slot 1. The capture that starts the first slot 0 after RUN entry is discarded.
- Frame complete: the capture that starts slot 0, with the primed flag set. Word = {`shreg`[30:0], `adcdat`}.
- Completion handling:
  - If `sample_valid` = 0, or `sample_ready` = 1 in that cycle: load `left` = word[31:16] and `right` = word[15:0]; `sample_valid` becomes 1.
  - Otherwise: drop the word, keep the held pair, set `overrun`.
- Transfer: occurs in any cycle with `sample_valid` = 1 and `sample_ready` = 1. `sample_valid` clears unless a completion loads in the same cycle, in which case it stays 1 with the new data.
- STOP:
  - Generation continues until the next frame-complete rise cycle.
  - That capture and completion are performed, but `b_clk` and `adc_lr_clk` stay low instead of rising.
  - State returns to IDLE.
  - If STOP is entered before the primed flag is set, return to IDLE at the same point without a completion.
- STOP -> RUN is not allowed. `enable` = 1 during STOP is ignored until IDLE is reached.

## Timing
- Reset values (asynchronous, immediate): all outputs 0; state IDLE; counters at IDLE values; primed flag 0. A reset mid-frame discards the partial frame.
- `b_clk` and `adc_lr_clk` are registered.
  - First `b_clk` rise: BCLK_DIV-1 clk edges... precisely, on the 1st clk edge after RUN is entered (`div_cnt` starts at BCLK_DIV-1).
  - `adc_lr_clk` rises on that same edge.
- First `sample_valid`: 32 `b_clk` periods (32·BCLK_DIV clk cycles) after the first `b_clk` rise. It is asserted on the same edge as that frame's `adc_lr_clk` rise.
- Completion rate: one per 32·BCLK_DIV clk cycles.
- `left`/`right` are stable whenever `sample_valid` = 1.
- `busy` falls on the same edge that enters IDLE.

## Test plan
- Reset: assert `rst_n` = 0 mid-frame -> all outputs 0 immediately. After release with `enable` = 0, the clocks stay low for 1000 cycles.
- Ratios (defaults): enable -> `m_clk` period 2 clk cycles; `b_clk` period 8 clk cycles; `adc_lr_clk` period 256 clk cycles with 128 high.
- Data path:
  - Stimulus: `adc_fm` `adcwrite` 32'hA5A5_3C3C every frame, `sample_ready` = 1.
  - Required: first valid 256 clk cycles after the first `b_clk` rise, with `left` = 16'hA5A5 and `right` = 16'h3C3C.
  - Then one-cycle valid pulses every 256 clk cycles.
- Backpressure:
  - Stimulus: `sample_ready` = 0 over frames 32'h1111_2222 then 32'h3333_4444.
  - Required: 16'h1111/16'h2222 held, `overrun` = 1, second frame dropped.
  - Then `sample_ready` = 1 -> the next frame 32'h5555_6666 loads.
- Simultaneous: `sample_ready` = 1 exactly on the completion cycle with valid held -> the new pair loads and `sample_valid` stays 1. No overrun.
- Stop: `enable` = 0 at slot 10 -> the current frame completes with one final valid. Then IDLE, `busy` = 0, and no further `b_clk` rise.

Source files
------------

// File: rtl/wm8731_adc_ctrl.sv
// wm8731_adc_ctrl: master-mode WM8731 ADC serial controller.
// Generates m_clk/b_clk/adc_lr_clk, deserialises adcdat into 16-bit L/R
// pairs and hands them downstream over a valid/ready handshake.
module wm8731_adc_ctrl #(
  parameter int MCLK_DIV = 2,
  parameter int BCLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adcdat,
  output logic        m_clk,
  output logic        b_clk,
  output logic        adc_lr_clk,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        busy
);

  localparam int DW = $clog2(BCLK_DIV);
  localparam int MW = (MCLK_DIV / 2 > 1) ? $clog2(MCLK_DIV / 2) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t         r_state;
  logic [DW-1:0]  r_div_cnt;
  logic [4:0]     r_bit_cnt;
  logic [MW-1:0]  r_mclk_cnt;
  logic           r_primed;
  logic [31:0]    r_shreg;

  logic           w_active;
  logic           w_rise;
  logic [DW-1:0]  w_div_nxt;
  logic [4:0]     w_bit_nxt;
  logic           w_frame_end;
  logic           w_complete;
  logic           w_stop_done;
  logic [31:0]    w_word;

  assign w_active    = (r_state != IDLE);
  assign w_rise      = w_active && (r_div_cnt == DIV_LAST);
  assign w_div_nxt   = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
  assign w_bit_nxt   = w_rise ? r_bit_cnt + 5'd1 : r_bit_cnt;
  assign w_frame_end = w_rise && (r_bit_cnt == 5'd31);
  assign w_complete  = w_frame_end && r_primed;
  assign w_stop_done = (r_state == STOP) && w_frame_end;
  assign w_word      = {r_shreg[30:0], adcdat};

  // Control FSM, clock generation, capture shift register and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_div_cnt    <= DIV_LAST;
      r_bit_cnt    <= 5'd31;
      r_mclk_cnt   <= '0;
      r_primed     <= 1'b0;
      r_shreg      <= '0;
      m_clk        <= 1'b0;
      b_clk        <= 1'b0;
      adc_lr_clk   <= 1'b0;
      left         <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if (w_complete) begin
        if (!sample_valid || sample_ready) begin
          left         <= w_word[31:16];
          right        <= w_word[15:0];
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= RUN;
            busy    <= 1'b1;
            overrun <= 1'b0;
          end
        end
        default: begin
          r_div_cnt <= w_div_nxt;
          r_bit_cnt <= w_bit_nxt;
          if (w_rise) begin
            r_shreg <= w_word;
            // Only a running interface may prime; a stop before slot 1 ends with no completion.
            if (r_state == RUN && r_bit_cnt == 5'd0) r_primed <= 1'b1;
          end
          if (r_mclk_cnt == MCLK_LAST) begin
            r_mclk_cnt <= '0;
            m_clk      <= ~m_clk;
          end else begin
            r_mclk_cnt <= r_mclk_cnt + 1'b1;
          end
          if (w_stop_done) begin
            // Final rise is suppressed: clocks park low and counters return to idle values.
            r_state    <= IDLE;
            busy       <= 1'b0;
            b_clk      <= 1'b0;
            adc_lr_clk <= 1'b0;
            m_clk      <= 1'b0;
            r_mclk_cnt <= '0;
            r_div_cnt  <= DIV_LAST;
            r_bit_cnt  <= 5'd31;
            r_primed   <= 1'b0;
          end else begin
            b_clk      <= (w_div_nxt < DIV_HALF);
            adc_lr_clk <= ~w_bit_nxt[4];
            if (r_state == RUN && !enable) r_state <= STOP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_adc_ctrl.sv
// tb_wm8731_adc_ctrl: randomized bench for wm8731_adc_ctrl with a
// time-based reference model (edges since RUN entry -> clocks and frames).
module tb_wm8731_adc_ctrl;

  localparam int unsigned BD = 8;
  localparam int unsigned FR = 32 * BD;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        adcdat;
  logic        m_clk;
  logic        b_clk;
  logic        adc_lr_clk;
  logic [15:0] left;
  logic [15:0] right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        busy;

  wm8731_adc_ctrl #(.MCLK_DIV(2), .BCLK_DIV(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adcdat(adcdat),
    .m_clk(m_clk), .b_clk(b_clk), .adc_lr_clk(adc_lr_clk),
    .left(left), .right(right), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state (values expected after the most recent clk edge)
  int unsigned t;
  bit          m_active, m_stop, m_primed, m_v, m_ovr, m_b, m_lr, m_m, m_busy;
  logic [15:0] m_l, m_r;
  logic [31:0] words [0:7];
  bit          en_ctl;
  int unsigned rdy_mode;  // 0 never, 1 always, 2 random, 3 only on completion edges

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0d time=%0t", tag, got, exp, t, $time);
    end
  endtask

  task automatic model_reset();
    t = 0; m_active = 0; m_stop = 0; m_primed = 0; m_v = 0; m_ovr = 0;
    m_b = 0; m_lr = 0; m_m = 0; m_busy = 0; m_l = '0; m_r = '0;
  endtask

  task automatic check_outs();
    chk("m_clk", {31'd0, m_clk}, {31'd0, m_m});
    chk("b_clk", {31'd0, b_clk}, {31'd0, m_b});
    chk("adc_lr_clk", {31'd0, adc_lr_clk}, {31'd0, m_lr});
    chk("sample_valid", {31'd0, sample_valid}, {31'd0, m_v});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("left", {16'd0, left}, {16'd0, m_l});
    chk("right", {16'd0, right}, {16'd0, m_r});
  endtask

  // Drive inputs for the coming edge and advance the model across it.
  task automatic drive_adv();
    int unsigned tn, g;
    logic [31:0] w;
    bit bnd, cmp, rdy;
    enable = en_ctl;
    tn  = t + 1;
    bnd = m_active && tn > 1 && ((tn - 1) % FR) == 0;
    cmp = bnd && (!m_stop || m_primed);
    case (rdy_mode)
      0: rdy = 1'b0;
      1: rdy = 1'b1;
      2: rdy = ($urandom_range(0, 3) != 0);
      default: rdy = cmp;
    endcase
    sample_ready = rdy;
    if (m_active && tn >= 2) begin
      g = (tn - 2) / BD;
      w = words[(g / 32) % 8];
      adcdat = w[31 - (g % 32)];
    end else begin
      adcdat = ($urandom_range(0, 1) == 1);
    end
    if (cmp) begin
      w = words[((tn - 1) / FR - 1) % 8];
      if (!m_v || rdy) begin
        m_l = w[31:16]; m_r = w[15:0]; m_v = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_v && rdy) begin
      m_v = 0;
    end
    if (!m_active) begin
      if (enable) begin
        m_active = 1; t = 0; m_stop = 0; m_primed = 0; m_ovr = 0;
      end
    end else begin
      t = tn;
      if (t == BD + 1 && !m_stop) m_primed = 1;
      if (m_stop && bnd) begin
        m_active = 0; m_b = 0; m_lr = 0; m_m = 0;
      end else begin
        m_b  = ((t - 1) % BD) < BD / 2;
        m_lr = (((t - 1) / BD) % 32) < 16;
        m_m  = (t % 2) == 1;
        if (!enable) m_stop = 1;
      end
    end
    m_busy = m_active;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outs();
    drive_adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    sample_ready = 1'b0;
    en_ctl = 1'b0;
    #1;
    chk("rst_m_clk", {31'd0, m_clk}, 32'd0);
    chk("rst_b_clk", {31'd0, b_clk}, 32'd0);
    chk("rst_lr", {31'd0, adc_lr_clk}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lr_data", {left, right}, 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive_adv();
  endtask

  task automatic stop_at_slot10();
    bit hit;
    hit = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_active && !m_stop && t >= 1 && (((t - 1) / BD) % 32) == 10) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk("stop_slot_reached", {31'd0, hit}, 32'd1);
    en_ctl = 1'b0;
    repeat (300) tick();
    chk("stop_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; enable = 1'b0; adcdat = 1'b0; sample_ready = 1'b0;
    en_ctl = 1'b0; rdy_mode = 1;
    model_reset();
    #2;
    do_reset();

    // idle after reset: clocks must stay low
    repeat (1000) tick();

    // data path, ready always high
    for (int i = 0; i < 8; i++) words[i] = 32'hA5A5_3C3C;
    rdy_mode = 1; en_ctl = 1'b1;
    repeat (1100) tick();
    stop_at_slot10();

    // backpressure: two frames with ready low, then ready high
    words[0] = 32'h1111_2222; words[1] = 32'h3333_4444; words[2] = 32'h5555_6666;
    for (int i = 3; i < 8; i++) words[i] = $urandom;
    rdy_mode = 0; en_ctl = 1'b1;
    repeat (2 * FR + 20) tick();
    chk("bp_left_held", {16'd0, left}, 32'h0000_1111);
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    rdy_mode = 1;
    repeat (FR + 20) tick();
    stop_at_slot10();

    // ready only on completion edges: back-to-back loads keep valid high
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    rdy_mode = 3; en_ctl = 1'b1;
    repeat (3 * FR + 20) tick();
    chk("sim_no_overrun", {31'd0, overrun}, 32'd0);
    stop_at_slot10();

    // random traffic with random ready, then mid-frame reset
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    rdy_mode = 2; en_ctl = 1'b1;
    repeat (4 * FR + $urandom_range(0, 100)) tick();
    stop_at_slot10();
    en_ctl = 1'b1;
    repeat (FR + $urandom_range(10, 200)) tick();
    do_reset();
    repeat (200) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
